// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter/sequencer shared by instruction fetch and load/store.
// Optional I/O write back-pressure is enabled by defining MEM_CTRL_IO_WAIT_EN.
module mem_ctrl #(
  parameter int          ADDR_W     = 32,
  parameter logic [1:0]  IO_MASK_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              mem_req_in,
  input  logic              mem_wr_in,
  input  logic [2:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_data_in,
  input  logic              io_full_in,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [1:0]        busy_out,
  output logic              inst_done_out,
  output logic [31:0]       inst_out,
  output logic              mem_done_out,
  output logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base, base_n, ram_a_n;
  logic [2:0]        len, len_n, cnt, cnt_n, req_len;
  logic [1:0]        idx;
  logic [31:0]       data, data_n, buffer, buffer_n, inst_n, mem_data_n;
  logic [7:0]        ram_dout_n;
  logic              ram_wr_n, inst_done_n, mem_done_n;
  logic [1:0]        busy_n;
  logic              stall_idle, stall_wr;

  always_comb begin
    case (mem_len_in)
      3'd1:    req_len = 3'd1;
      3'd2:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_IO_WAIT_EN
  assign stall_idle = (mem_addr_in[17:16] == IO_MASK_HI) && io_full_in;
  assign stall_wr   = (base[17:16] == IO_MASK_HI) && io_full_in;
`else
  logic unused_io;
  assign unused_io  = io_full_in ^ (^IO_MASK_HI);
  assign stall_idle = 1'b0;
  assign stall_wr   = 1'b0;
`endif

  // cnt counts edges since acceptance in reads (byte cnt-2 arrives on ram_din),
  // and counts bytes already issued in writes.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    base_n      = base;
    len_n       = len;
    data_n      = data;
    buffer_n    = buffer;
    ram_a_n     = ram_a;
    ram_dout_n  = ram_dout;
    ram_wr_n    = 1'b0;
    busy_n      = busy_out;
    inst_done_n = 1'b0;
    mem_done_n  = 1'b0;
    inst_n      = inst_out;
    mem_data_n  = mem_data_out;
    idx         = cnt[1:0] - 2'd2;

    case (state)
      IDLE: begin
        if (mem_req_in) begin
          base_n   = mem_addr_in;
          len_n    = req_len;
          data_n   = mem_data_in;
          buffer_n = '0;
          busy_n   = 2'b01;
          if (mem_wr_in) begin
            state_n = MEM_WR;
            if (stall_idle) begin
              cnt_n = 3'd0;
            end else begin
              ram_a_n    = mem_addr_in;
              ram_dout_n = mem_data_in[7:0];
              ram_wr_n   = 1'b1;
              cnt_n      = 3'd1;
            end
          end else begin
            state_n = MEM_RD;
            ram_a_n = mem_addr_in;
            cnt_n   = 3'd1;
          end
        end else if (if_req_in && !clear_in) begin
          state_n  = IF_RD;
          base_n   = if_addr_in;
          len_n    = 3'd4;
          buffer_n = '0;
          busy_n   = 2'b10;
          ram_a_n  = if_addr_in;
          cnt_n    = 3'd1;
        end
      end

      IF_RD, MEM_RD: begin
        if (state == IF_RD && clear_in) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          busy_n  = 2'b00;
        end else begin
          if (cnt < len)
            ram_a_n = base + ADDR_W'(cnt);
          if (cnt >= 3'd2)
            buffer_n[{idx, 3'b000} +: 8] = ram_din;
          cnt_n = cnt + 3'd1;
          if (cnt == len + 3'd1) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            busy_n  = 2'b00;
            if (state == IF_RD) begin
              inst_n      = buffer_n;
              inst_done_n = 1'b1;
            end else begin
              mem_data_n = buffer_n;
              mem_done_n = 1'b1;
            end
          end
        end
      end

      MEM_WR: begin
        if (cnt == len) begin
          state_n    = IDLE;
          cnt_n      = 3'd0;
          busy_n     = 2'b00;
          ram_a_n    = '0;
          mem_done_n = 1'b1;
        end else if (!stall_wr) begin
          ram_a_n    = base + ADDR_W'(cnt);
          ram_dout_n = data[{cnt[1:0], 3'b000} +: 8];
          ram_wr_n   = 1'b1;
          cnt_n      = cnt + 3'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      base          <= '0;
      len           <= '0;
      data          <= '0;
      buffer        <= '0;
      ram_a         <= '0;
      ram_dout      <= '0;
      ram_wr        <= 1'b0;
      busy_out      <= 2'b00;
      inst_done_out <= 1'b0;
      mem_done_out  <= 1'b0;
      inst_out      <= '0;
      mem_data_out  <= '0;
    end else if (rdy_in) begin
      state         <= state_n;
      cnt           <= cnt_n;
      base          <= base_n;
      len           <= len_n;
      data          <= data_n;
      buffer        <= buffer_n;
      ram_a         <= ram_a_n;
      ram_dout      <= ram_dout_n;
      ram_wr        <= ram_wr_n;
      busy_out      <= busy_n;
      inst_done_out <= inst_done_n;
      mem_done_out  <= mem_done_n;
      inst_out      <= inst_n;
      mem_data_out  <= mem_data_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected words/writes are queued at issue and
// retired when the DUT pulses done or asserts ram_wr.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in, if_req_in, mem_req_in, mem_wr_in, io_full_in;
  logic [31:0] if_addr_in, mem_addr_in, mem_data_in;
  logic [2:0]  mem_len_in;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [1:0]  busy_out;
  logic        inst_done_out, mem_done_out;
  logic [31:0] inst_out, mem_data_out;

  mem_ctrl #(.ADDR_W(32), .IO_MASK_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in), .mem_len_in(mem_len_in),
    .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .io_full_in(io_full_in),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy_out(busy_out), .inst_done_out(inst_done_out), .inst_out(inst_out),
    .mem_done_out(mem_done_out), .mem_data_out(mem_data_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  // RAM port is stalled along with the chip when rdy_in is low
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
      ram_din <= ram[ram_a[15:0]];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_inst [$];
  logic [32:0] q_mem  [$];
  logic [39:0] q_wr   [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && rdy_in) begin
      if (inst_done_out) begin
        if (q_inst.size() == 0) check("inst_extra", 64'(inst_done_out), 64'd0);
        else check("inst_data", 64'(inst_out), 64'(q_inst.pop_front()));
      end
      if (mem_done_out) begin
        if (q_mem.size() == 0) check("mem_extra", 64'(mem_done_out), 64'd0);
        else begin
          logic [32:0] e;
          e = q_mem.pop_front();
          if (e[32]) check("load_data", 64'(mem_data_out), 64'(e[31:0]));
        end
      end
      if (ram_wr) begin
        if (q_wr.size() == 0) check("wr_extra", 64'(ram_wr), 64'd0);
        else check("wr_addr_data", 64'({ram_a, ram_dout}), 64'(q_wr.pop_front()));
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[16'(a + 32'(k))];
    return w;
  endfunction

  function automatic int nbytes(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[15:0]]     = b;
    ref_mem[a[15:0]] = b;
  endtask

  task automatic wait_pulse(input bit is_mem, input int limit, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < limit) begin
      @(negedge clk_in);
      cyc++;
      hit = is_mem ? mem_done_out : inst_done_out;
    end
    if (!hit) check(is_mem ? "mem_timeout" : "inst_timeout", 64'(hit), 64'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int lat);
    int cyc;
    q_inst.push_back(ref_word(a, 4));
    if_addr_in = a;
    if_req_in  = 1'b1;
    wait_pulse(1'b0, 40, cyc);
    if_req_in = 1'b0;
    if (lat >= 0) check("fetch_lat", 64'(cyc - 1), 64'(lat));
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] len, input int lat);
    int cyc;
    q_mem.push_back({1'b1, ref_word(a, nbytes(len))});
    mem_addr_in = a;
    mem_len_in  = len;
    mem_wr_in   = 1'b0;
    mem_req_in  = 1'b1;
    wait_pulse(1'b1, 40, cyc);
    mem_req_in = 1'b0;
    check("load_lat", 64'(cyc - 1), 64'(lat));
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] len, input logic [31:0] d,
                          input int lat);
    int cyc;
    for (int k = 0; k < nbytes(len); k++) begin
      q_wr.push_back({a + 32'(k), d[8*k +: 8]});
      ref_mem[16'(a + 32'(k))] = d[8*k +: 8];
    end
    q_mem.push_back({1'b0, 32'h0});
    mem_addr_in = a;
    mem_len_in  = len;
    mem_data_in = d;
    mem_wr_in   = 1'b1;
    mem_req_in  = 1'b1;
    wait_pulse(1'b1, 40, cyc);
    mem_req_in = 1'b0;
    check("store_lat", 64'(cyc - 1), 64'(lat));
  endtask

  initial begin
    int          cyc;
    logic [31:0] saved_a;

    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; if_req_in = 1'b0; mem_req_in = 1'b0;
    mem_wr_in = 1'b0; io_full_in = 1'b0; if_addr_in = '0; mem_addr_in = '0;
    mem_data_in = '0; mem_len_in = '0;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);

    repeat (2) @(negedge clk_in);
    check("rst_ram",   64'({ram_a, ram_dout, ram_wr}), 64'd0);
    check("rst_busy",  64'(busy_out), 64'd0);
    check("rst_done",  64'({inst_done_out, mem_done_out}), 64'd0);
    check("rst_inst",  64'(inst_out), 64'd0);
    check("rst_mdata", 64'(mem_data_out), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Directed fetch at 0x100
    q_inst.push_back(32'h0010_0513);
    if_addr_in = 32'h100;
    if_req_in  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("fetch_a", 64'(ram_a), 64'(32'h100 + 32'(k)));
      check("fetch_busy", 64'(busy_out), 64'(2'b10));
    end
    wait_pulse(1'b0, 10, cyc);
    if_req_in = 1'b0;
    check("fetch_done_at5", 64'(cyc), 64'd2);
    check("fetch_busy_idle", 64'(busy_out), 64'd0);
    @(negedge clk_in);
    check("fetch_single_pulse", 64'(inst_done_out), 64'd0);

    // MEM beats IF when both are raised together
    q_mem.push_back({1'b1, ref_word(32'h200, 4)});
    q_inst.push_back(ref_word(32'h104, 4));
    mem_addr_in = 32'h200; mem_len_in = 3'd4; mem_wr_in = 1'b0; mem_req_in = 1'b1;
    if_addr_in  = 32'h104; if_req_in = 1'b1;
    @(negedge clk_in);
    check("arb_busy_mem", 64'(busy_out), 64'(2'b01));
    check("arb_a_mem", 64'(ram_a), 64'h200);
    wait_pulse(1'b1, 20, cyc);
    mem_req_in = 1'b0;
    check("arb_mem_lat", 64'(cyc), 64'd5);
    @(negedge clk_in);
    check("arb_busy_if", 64'(busy_out), 64'(2'b10));
    check("arb_a_if", 64'(ram_a), 64'h104);
    wait_pulse(1'b0, 20, cyc);
    if_req_in = 1'b0;
    check("arb_if_lat", 64'(cyc), 64'd5);

    // Store len 2 crossing 0x2FF -> 0x300
    q_wr.push_back({32'h2FF, 8'hCD});
    q_wr.push_back({32'h300, 8'hAB});
    q_mem.push_back({1'b0, 32'h0});
    ref_mem[16'h2FF] = 8'hCD;
    ref_mem[16'h300] = 8'hAB;
    mem_addr_in = 32'h2FF; mem_len_in = 3'd2; mem_data_in = 32'h1234_ABCD;
    mem_wr_in = 1'b1; mem_req_in = 1'b1;
    @(negedge clk_in);
    check("st_wr1", 64'({ram_wr, mem_done_out}), 64'b10);
    @(negedge clk_in);
    check("st_wr2", 64'({ram_wr, mem_done_out}), 64'b10);
    @(negedge clk_in);
    check("st_done", 64'({ram_wr, mem_done_out, busy_out}), 64'b0100);
    check("st_a_zero", 64'(ram_a), 64'd0);
    mem_req_in = 1'b0;
    @(negedge clk_in);

    do_load(32'h2FE, 3'd4, 5);
    do_load(32'h2FF, 3'd2, 3);
    do_load(32'h300, 3'd1, 2);
    do_load(32'h2FF, 3'd3, 5);
    do_load(32'h2FF, 3'd0, 5);
    do_store(32'h310, 3'd4, $urandom, 4);
    do_load(32'h310, 3'd4, 5);
    do_store(32'h320, 3'd1, $urandom, 1);
    do_load(32'h31F, 3'd2, 3);
    do_fetch(32'hFFFF_FFFE, 5);

    // Abort a fetch in its third IF_RD cycle
    if_addr_in = 32'h108; if_req_in = 1'b1;
    repeat (3) @(negedge clk_in);
    clear_in = 1'b1; if_req_in = 1'b0;
    @(negedge clk_in);
    check("abort_idle", 64'({busy_out, inst_done_out}), 64'd0);
    clear_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("abort_no_done", 64'(inst_done_out), 64'd0);

    // clear_in blocks acceptance in IDLE on the same edge
    poke(32'h400, 8'hEF); poke(32'h401, 8'hBE); poke(32'h402, 8'hAD); poke(32'h403, 8'hDE);
    clear_in = 1'b1; if_addr_in = 32'h400; if_req_in = 1'b1;
    @(negedge clk_in);
    check("clear_idle_block", 64'(busy_out), 64'd0);
    clear_in = 1'b0;
    q_inst.push_back(32'hDEAD_BEEF);
    wait_pulse(1'b0, 20, cyc);
    if_req_in = 1'b0;
    check("post_abort_lat", 64'(cyc), 64'd6);

    // rdy_in freeze mid-fetch
    q_inst.push_back(ref_word(32'h404, 4));
    if_addr_in = 32'h404; if_req_in = 1'b1;
    repeat (2) @(negedge clk_in);
    #1 rdy_in = 1'b0;
    saved_a = ram_a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("freeze_a", 64'({ram_a, busy_out}), 64'({saved_a, 2'b10}));
    end
    #1 rdy_in = 1'b1;
    wait_pulse(1'b0, 20, cyc);
    if_req_in = 1'b0;

    // Done pulse held across a freeze, then lasts one cycle
    q_mem.push_back({1'b1, ref_word(32'h123, 1)});
    mem_addr_in = 32'h123; mem_len_in = 3'd1; mem_wr_in = 1'b0; mem_req_in = 1'b1;
    wait_pulse(1'b1, 10, cyc);
    #1 rdy_in = 1'b0; mem_req_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      check("done_held", 64'(mem_done_out), 64'd1);
    end
    #1 rdy_in = 1'b1;
    @(negedge clk_in);
    check("done_released", 64'(mem_done_out), 64'd0);

    // Asynchronous reset in the middle of a store
    mem_addr_in = 32'h500; mem_len_in = 3'd4; mem_data_in = 32'h0102_0304;
    mem_wr_in = 1'b1; mem_req_in = 1'b1;
    q_wr.push_back({32'h500, 8'h04});
    @(negedge clk_in);
    check("rst_mid_wr_before", 64'({ram_wr, busy_out}), 64'b101);
    #2 rst_in = 1'b1;
    #1;
    check("rst_mid_wr_after", 64'({ram_wr, busy_out}), 64'd0);
    mem_req_in = 1'b0;
    q_wr.delete();
    q_mem.delete();
    ram[16'h500] = ref_mem[16'h500];
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);

`ifdef MEM_CTRL_IO_WAIT_EN
    q_wr.push_back({32'h3_0000, 8'h5A});
    q_mem.push_back({1'b0, 32'h0});
    ref_mem[16'h0000] = 8'h5A;
    io_full_in = 1'b1;
    mem_addr_in = 32'h3_0000; mem_len_in = 3'd1; mem_data_in = 32'h0000_005A;
    mem_wr_in = 1'b1; mem_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      check("io_stall", 64'({ram_wr, busy_out, mem_done_out}), 64'b0010);
    end
    io_full_in = 1'b0;
    @(negedge clk_in);
    check("io_issue", 64'({ram_wr, mem_done_out}), 64'b10);
    wait_pulse(1'b1, 10, cyc);
    mem_req_in = 1'b0;
    check("io_done_next", 64'(cyc), 64'd1);
`else
    io_full_in = 1'b1;
    do_store(32'h3_0000, 3'd1, 32'h0000_005A, 1);
    io_full_in = 1'b0;
`endif
    do_load(32'h3_0000, 3'd1, 2);
    do_fetch(32'h100, 5);

    repeat (3) @(negedge clk_in);
    check("queues_drained", 64'(q_inst.size() + q_mem.size() + q_wr.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
